// File: rtl/uart_tx_if.sv
`timescale 1ns/1ps
// Byte-in / serial-out port bundle of the UART transmitter.
// Latency: none (wires only).
// Backpressure: the requester holds start until it sees busy low.
interface uart_tx_if;
    logic       start;
    logic [7:0] data;
    logic       tx_line;
    logic       busy;
    logic       finish;

    // Requester side: offers a byte and watches line/status.
    modport master (
        output start,
        output data,
        input  tx_line,
        input  busy,
        input  finish
    );

    // Transmitter side.
    modport slave (
        input  start,
        input  data,
        output tx_line,
        output busy,
        output finish
    );
endinterface

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// UART transmitter: start bit, 8 data bits LSB first, optional even parity
// (UART_TX_PARITY_EN), one stop bit. Latency: tx_line drops 1 clock after accept.
// Backpressure: busy high for the whole frame; start while busy is dropped, not queued.
module uart_tx #(
    parameter int DELAY_COUNTS = 2083
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    // Bit-period counter width; guard the degenerate single-bit case.
    localparam int CNT_W = (DELAY_COUNTS > 2) ? $clog2(DELAY_COUNTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_COUNTS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       bit_idx_q;
    logic [3:0]       bit_idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_q;
    logic             tx_d;
    logic             bit_done;

`ifdef UART_TX_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    // Last clock of the current bit period.
    assign bit_done = (cnt_q == CNT_LAST);

    // Status is a pure decode of the registered state, so it is glitch-free
    // and finish can never be seen without busy.
    assign bus.busy    = (state_q != IDLE);
    assign bus.finish  = (state_q == STOP) && bit_done;
    assign bus.tx_line = tx_q;

    // Next-state, counter, shifter and next line level.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = bit_done ? '0 : cnt_q + CNT_W'(1);
        tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d   = START;
                    shift_d   = bus.data;
                    bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^bus.data;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 4'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every bit period starts from zero on a state change.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // The line is registered: compute the level the next state drives.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that converts a parallel byte into an asynchronous frame: start bit, 8 data bits LSB first, optional even-parity bit, and one stop bit. It is the transmit half of the UART full-duplex block and drives the TX GPIO line. Bit period uses the same clock-count timing as the receive path, so a transmitter/receiver pair built with matching parameters interoperates at the same baud rate.

## Interface
- DELAY_COUNTS, 2083, clock cycles per bit period; legal range ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high. Single clock domain.
- start  input  1  request to send; sampled only while busy = 0.
- data  input  8  byte to send; captured on the accepting edge and ignored afterwards.
- tx_line  output  1  serial line, registered, idle high.
- busy  output  1  high from the accepting edge until the frame completes.
- finish  output  1  one-cycle pulse in the last clock of the stop bit.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP. PARITY exists only with UART_TX_PARITY_EN.
- Internal counters:
  - Bit-period counter, ceil(log2(DELAY_COUNTS)) bits, counts 0 to DELAY_COUNTS−1. The end-of-bit flag is asserted at DELAY_COUNTS−1. The counter clears on every state change.
  - 4-bit data-bit counter, 0 to 7.
  - 8-bit shift register, shifted right at each data-bit boundary.
- IDLE:
  - tx_line = 1, busy = 0.
  - If start = 1, capture data into the shift register, go to START and set busy = 1.
  - With UART_TX_PARITY_EN, also compute parity = XOR(data) on the same edge.
- START: tx_line = 0 for DELAY_COUNTS cycles, then go to DATA with bit counter = 0.
- DATA:
  - tx_line = shift_reg[0].
  - At end of bit, shift right and increment the bit counter.
  - After bit 7, go to PARITY or STOP.
- PARITY: tx_line = even-parity bit, so the total count of ones across data and parity is even. Lasts DELAY_COUNTS cycles, then go to STOP.
- STOP:
  - tx_line = 1 for DELAY_COUNTS cycles.
  - finish = 1 during the final cycle of the stop bit.
  - Then go to IDLE; busy = 0 from that edge.
- start while busy = 1 is ignored. It is not queued.
- data changes after acceptance have no effect on the frame in flight.
- Reset values, applied synchronously from any state including mid-frame:
  - state = IDLE.
  - tx_line = 1, busy = 0, finish = 0.
  - Both counters = 0, shift register = 0, parity = 0.
  - A truncated frame is never resumed.

## Timing
- Accepting edge E (start = 1, busy = 0): tx_line goes low and busy goes high in the cycle after E. Latency is 1 clock.
- Frame length N = DELAY_COUNTS × 10 (8N1) or × 11 (8E1) clocks, measured from the first low cycle of tx_line.
- Data bit i occupies cycles [E+1+(i+1)·D, E+1+(i+2)·D), where D = DELAY_COUNTS.
- finish is high in exactly one cycle, E+N. busy is high in cycles E+1 through E+N inclusive.
- At edge E+N+1 the state is IDLE. The earliest next accepting edge is E+N+1, which guarantees at least one extra idle-high clock between frames.
- With start held high continuously, frames repeat with a period of N+1 clocks.
- finish and busy never both go low in the same cycle as they rise. finish = 1 always implies busy = 1.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: 8E1 frame. The PARITY state and parity register are compiled in, and N = 11·D.
  - Undefined: 8N1 frame. DATA goes directly to STOP, no parity logic is built, and N = 10·D.
  - The receive side counts 9 bits (8 data + 1 parity), so the full-duplex top defines this macro by default.

## Test plan
- Reset and idle: assert rst for 3 clocks with DELAY_COUNTS = 4.
  - Expect tx_line = 1, busy = 0, finish = 0 throughout, and no activity for 50 clocks with start = 0.
- Single frame, data = 0x55, D = 4, parity enabled:
  - tx_line sequence per 4-clock bit is 0,1,0,1,0,1,0,1,0,0,1 (start, LSB-first data, parity = 0, stop).
  - busy is high for 44 clocks; finish pulses once at clock 44.
- Parity = 1 case, data = 0x07: data bits 1,1,1,0,0,0,0,0, then parity bit = 1.
  - Without the macro the same stimulus gives a 40-clock frame with no parity bit.
- Busy lockout: pulse start with 0xA3, then pulse start with 0xFF at clock 10.
  - Only 0xA3 is transmitted; the second request is dropped.
  - Changing data mid-frame does not alter the output.
- Back-to-back: hold start = 1 with data = 0x00 then 0xFF.
  - Frames begin every N+1 = 45 clocks, with exactly one extra idle-high clock between stop and next start.
- Reset mid-frame: assert rst during data bit 3.
  - The next clock shows tx_line = 1 and busy = 0; no finish pulse.
  - A subsequent start sends a complete, correct frame.
